keypad_scan_4x4: RTL and testbench
==================================

# keypad_scan_4x4

Scans a 4x4 active-low matrix keypad, debounces and encodes one key press at a time, and produces the `num`/`wr` pair consumed by the two-digit seven-segment display block. Each accepted key shifts a hex nibble into an 8-bit value, so the last two keys pressed appear on the display. The block sits between the board keypad pins and the display register write port.

## Interface
- `SCAN_DIV`, default 1000, clock cycles per row slot (must be ≥ 4).
- `DEBOUNCE`, default 4, consecutive identical scan frames required to accept a press or a release (≥ 1, ≤ 15).
- `clk`  input  1  system clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `col_n`  input  4  keypad column lines, active-low, pulled up externally, asynchronous to `clk`.
- `row_n`  output  4  keypad row drive, active-low, exactly one bit low at all times.
- `num`  output  8  display value: {previous key code, latest key code}.
- `wr`  output  1  one-cycle write strobe to the display register; `num` is valid in the same cycle.
- `key_code`  output  4  code of the most recently accepted key.
- `key_valid`  output  1  high while an accepted key is held (state HELD).

## Operation
- `col_n` passes through a 2-flop synchronizer before any use.
- A slot counter counts 0..SCAN_DIV-1. A row index 0..3 advances when the counter wraps; `row_n = ~(4'b0001 << row_idx)`.
- Synchronized columns are sampled on the last cycle of each slot (count = SCAN_DIV-1) and stored per row. A frame is the four slots of rows 0..3; the frame result is evaluated when row 3's sample is taken.
- Frame result: zero keys low → NONE; exactly one key low → KEY(code); two or more → NONE (ghosting/multi-press is rejected).
- Code mapping: row r, column c → code = {r[1:0], c[1:0]} (row 0/col 0 = 0x0, row 3/col 3 = 0xF).
- FSM states:
  - IDLE: a KEY frame latches the candidate, sets cnt = 1, and moves to DEB. If DEBOUNCE = 1, the key is accepted immediately instead.
  - DEB: a frame with the same key increments cnt. When cnt reaches DEBOUNCE, the key is accepted and the FSM moves to HELD. A different key or NONE returns to IDLE.
  - HELD: any KEY frame resets rcnt to 0. A NONE frame increments rcnt; at DEBOUNCE the FSM moves to IDLE.
- Accept action, registered: `num <= {num[3:0], code}`, `key_code <= code`, and `wr` high for exactly one cycle.
- A key held indefinitely produces exactly one `wr`; there is no auto-repeat.
- A different key appearing in HELD without an intervening release is ignored.

## Timing
- Reset values: `row_n = 4'b1110`, `num = 8'h00`, `key_code = 4'h0`, `key_valid = 0`, `wr = 0`, FSM in IDLE, all counters 0.
- Frame length is 4·SCAN_DIV cycles. Input-to-sample latency is 2 cycles (synchronizer) plus the remainder of the row slot.
- `wr` and the new `num` rise on the cycle after the accepting frame's row-3 sample. `key_valid` rises on that same cycle.
- `key_valid` falls on the cycle after the DEBOUNCE-th consecutive NONE frame.
- Minimum press-to-`wr` latency is DEBOUNCE frames.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously). No `wr` is emitted during or after reset for a partially debounced key.
- When counter wrap and frame evaluation coincide, the evaluation uses the completed frame; the new row drive takes effect in the same cycle.

## Structure
- Package `keypad_pkg` holds the FSM state enum (IDLE, DEB, HELD) and the frame-result constants `KEY_W = 4` and `ROWS = 4`.
- Sub-module `Sync_2FF_4bit`: 2-flop column synchronizer with asynchronous active-low reset, reset value 4'b1111.
- Scan counter, frame evaluation, and FSM remain in the top module.

## Test plan
All scenarios use `SCAN_DIV = 4` and `DEBOUNCE = 2` (frame = 16 cycles).
- Reset: release `rst`, idle with `col_n = 4'hF` → `row_n` cycles 1110, 1101, 1011, 0111 every 4 cycles; `wr` never asserts; `num = 8'h00`.
- Single key: press row 1/col 2 (pull `col_n[2]` low while `row_n[1] = 0`) for 3 frames → exactly one `wr` pulse, `num = 8'h06`, `key_code = 6`, `key_valid = 1`.
- Second key: release for 2 frames, then press row 3/col 3 → `num = 8'h6F`, exactly one additional `wr`.
- Bounce: press 0x5 for one frame, NONE for one frame, repeated 4 times → no `wr`, `num` unchanged.
- Ghosting: hold 0x1 and 0x2 together for 4 frames → no `wr`. Then release 0x2 and keep 0x1 → `wr` with `num` low nibble = 1.
- Reset mid-debounce: assert `rst` during DEB with 0xA held, then deassert with the key still held → outputs return to reset values, and the key is accepted afresh after 2 frames with `num = 8'h0A`.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;

  // Debounce/acceptance FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } kp_state_t;

  // Result of evaluating one complete scan frame
  typedef struct packed {
    logic             hit;   // exactly one key low in the frame
    logic [KEY_W-1:0] code;  // {row, col} of that key
  } frame_res_t;

endpackage

// File: rtl/keypad_scan_4x4_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module Sync_2FF_4bit
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] d,
  output logic [COLS-1:0] q
);

  logic [COLS-1:0] meta;

  // Resets to all-ones so an idle (pulled-up) keypad is seen during reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// Row-scanning 4x4 keypad reader: debounces one key at a time and shifts
// each accepted key code into an 8-bit display value with a write strobe.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] num,
  output logic       wr,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned CNT_W      = $clog2(SCAN_DIV);
  localparam int unsigned ROW_W      = $clog2(ROWS);
  localparam int unsigned DEB_W      = 4;
  localparam int unsigned FRAME_BITS = ROWS * COLS;

  logic [COLS-1:0]   col_s;
  logic [CNT_W-1:0]  slot_cnt;
  logic [ROW_W-1:0]  row_idx;
  logic [ROW_W-1:0]  row_nxt_c;
  logic [11:0]       samp;        // column samples of rows 0..2
  logic              slot_end_c;
  logic              frame_end_c;
  logic [FRAME_BITS-1:0] frame_c; // bit index == key code, low = pressed
  logic [4:0]        low_cnt_c;
  frame_res_t        res_c;

  kp_state_t         state_q, state_d;
  logic [KEY_W-1:0]  cand_q, cand_d;
  logic [DEB_W-1:0]  dcnt_q, dcnt_d;
  logic [DEB_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]        num_d;
  logic [KEY_W-1:0]  code_d;
  logic              wr_d;
  logic              valid_d;
  logic              accept_c;

  Sync_2FF_4bit u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  assign slot_end_c  = (slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end_c = slot_end_c && (row_idx == ROW_W'(ROWS - 1));
  assign row_nxt_c   = row_idx + ROW_W'(1);
  // Row 3 is evaluated from the live synchronized columns on its sample cycle
  assign frame_c     = {col_s, samp};

  // Slot counter, row drive and per-row column sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      row_idx  <= '0;
      row_n    <= 4'b1110;
      samp     <= '1;
    end else if (slot_end_c) begin
      slot_cnt <= '0;
      row_idx  <= row_nxt_c;
      row_n    <= ~(4'b0001 << row_nxt_c);
      case (row_idx)
        ROW_W'(0): samp[3:0]  <= col_s;
        ROW_W'(1): samp[7:4]  <= col_s;
        ROW_W'(2): samp[11:8] <= col_s;
        default:   ;
      endcase
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // Frame evaluation: exactly one low key is a hit, anything else is none
  always_comb begin
    low_cnt_c = '0;
    res_c     = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (!frame_c[i]) begin
        low_cnt_c  = low_cnt_c + 5'd1;
        res_c.code = KEY_W'(i);
      end
    end
    res_c.hit = (low_cnt_c == 5'd1);
  end

  // Next-state and output logic of the debounce FSM
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    num_d    = num;
    code_d   = key_code;
    wr_d     = 1'b0;
    accept_c = 1'b0;

    if (frame_end_c) begin
      case (state_q)
        IDLE: begin
          if (res_c.hit) begin
            cand_d = res_c.code;
            dcnt_d = DEB_W'(1);
            if (DEBOUNCE == 1) accept_c = 1'b1;
            else               state_d  = DEB;
          end
        end
        DEB: begin
          if (res_c.hit && (res_c.code == cand_q)) begin
            dcnt_d = dcnt_q + DEB_W'(1);
            if (dcnt_d == DEB_W'(DEBOUNCE)) accept_c = 1'b1;
          end else begin
            state_d = IDLE;
            dcnt_d  = '0;
          end
        end
        HELD: begin
          if (res_c.hit) begin
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + DEB_W'(1);
            if (rcnt_d == DEB_W'(DEBOUNCE)) begin
              state_d = IDLE;
              rcnt_d  = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept_c) begin
      state_d = HELD;
      dcnt_d  = '0;
      rcnt_d  = '0;
      num_d   = {num[3:0], cand_d};
      code_d  = cand_d;
      wr_d    = 1'b1;
    end

    valid_d = (state_d == HELD);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      num       <= 8'h00;
      key_code  <= 4'h0;
      wr        <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      num       <= num_d;
      key_code  <= code_d;
      wr        <= wr_d;
      key_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4: frame-level reference model with
// a write-strobe scoreboard.
module tb_keypad_scan_4x4;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 2;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] num;
  logic       wr;
  logic [3:0] key_code;
  logic       key_valid;

  logic [15:0] pressed = '0;   // bit k set = key with code k held down

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int wr_expected = 0;

  typedef struct {
    logic [7:0] num;
    logic [3:0] code;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (frame granularity)
  bit         m_held;
  bit         m_pending;
  logic [3:0] m_cand;
  int         m_streak;
  int         m_quiet;
  logic [7:0] m_num;
  logic [3:0] m_code;

  keypad_scan_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .num       (num),
    .wr        (wr),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key connects its row drive to its column line
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_pending = 0; m_cand = '0;
    m_streak = 0; m_quiet = 0; m_num = '0; m_code = '0;
  endtask

  task automatic model_accept();
    m_held    = 1;
    m_pending = 0;
    m_quiet   = 0;
    m_num     = {m_num[3:0], m_cand};
    m_code    = m_cand;
    exp_q.push_back('{num: m_num, code: m_code});
    wr_expected++;
  endtask

  // Apply the debounce rules to one completed frame of held keys
  task automatic model_frame(input logic [15:0] set);
    int n;
    logic [3:0] k;
    bit is_key;
    n = $countones(set);
    k = '0;
    for (int i = 0; i < 16; i++) if (set[i]) k = 4'(i);
    is_key = (n == 1);
    if (m_held) begin
      if (is_key) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == DEBOUNCE) begin m_held = 0; m_quiet = 0; end
      end
    end else if (m_pending) begin
      if (is_key && k == m_cand) begin
        m_streak++;
        if (m_streak == DEBOUNCE) model_accept();
      end else begin
        m_pending = 0;
        m_streak  = 0;
      end
    end else if (is_key) begin
      m_cand   = k;
      m_streak = 1;
      if (DEBOUNCE == 1) model_accept();
      else m_pending = 1;
    end
  endtask

  // Hold a key set for one full frame, then compare against the model
  task automatic run_frame(input logic [15:0] set);
    pressed = set;
    repeat (FRAME) @(posedge clk);
    #1;
    check("wr_missing", 32'(exp_q.size()), 0);
    model_frame(set);
    check("num", 32'(num), 32'(m_num));
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_held));
  endtask

  task automatic check_reset_vals();
    check("rst_row_n", 32'(row_n), 32'h0000_000E);
    check("rst_num", 32'(num), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
  endtask

  // Scoreboard monitor: every wr pulse must match the next expected write
  always @(negedge clk) begin
    exp_t e;
    if (wr !== 1'b0) begin
      wr_seen++;
      check("wr_pending", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_num", 32'(num), 32'(e.num));
        check("wr_code", 32'(key_code), 32'(e.code));
      end
    end
  end

  initial begin
    logic [3:0]  exp_row;
    logic [15:0] s;
    int kind, len, a, b;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();

    // Idle scan: row drive rotates every SCAN_DIV cycles, no writes
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("row_n_scan", 32'(row_n), 32'(exp_row));
      @(negedge clk);
    end

    // Single key 0x6, release, then 0xF
    repeat (3) run_frame(16'h0040);
    repeat (2) run_frame(16'h0000);
    repeat (3) run_frame(16'h8000);
    repeat (2) run_frame(16'h0000);

    // Bouncing 0x5 never settles
    repeat (4) begin
      run_frame(16'h0020);
      run_frame(16'h0000);
    end

    // Two keys together are rejected; the survivor is then accepted
    repeat (4) run_frame(16'h0006);
    repeat (3) run_frame(16'h0002);
    repeat (2) run_frame(16'h0000);

    // Reset while 0xA is part-way through debounce
    run_frame(16'h0400);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    repeat (3) run_frame(16'h0400);
    repeat (2) run_frame(16'h0000);

    // Randomized key sequences, including direct key-to-key switches
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 3);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       s = 16'h0000;
        3:       s = (16'(1) << a) | (16'(1) << b);
        default: s = 16'(1) << a;
      endcase
      repeat (len) run_frame(s);
    end
    repeat (DEBOUNCE + 1) run_frame(16'h0000);

    check("queue_drained", 32'(exp_q.size()), 0);
    check("wr_total", 32'(wr_seen), 32'(wr_expected));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
